// File: rtl/ex_pkg.sv
// Shared decode/execute definitions: opcodes, class codes, ex_ctrl layout,
// integer ALU and predicate operation codes.
package ex_pkg;

  localparam int EXC_W    = 7;
  localparam int EXC_SRC1 = 6;
  localparam int EXC_SRC2 = 5;
  localparam int EXC_OPHI = 4;
  localparam int EXC_OPLO = 1;
  localparam int EXC_INT  = 0;

  localparam logic [1:0] CLS_INT_RR = 2'b00;
  localparam logic [1:0] CLS_INT_RI = 2'b01;
  localparam logic [1:0] CLS_PRED   = 2'b10;
  localparam logic [1:0] CLS_MISC   = 2'b11;

  localparam logic [5:0] OP_JAL = 6'h30;
  localparam logic [5:0] OP_LD  = 6'h31;
  localparam logic [5:0] OP_ST  = 6'h32;
  localparam logic [5:0] OP_NOP = 6'h3F;

  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_MUL  = 4'b0011;
  localparam logic [3:0] ALU_DIV  = 4'b0100;
  localparam logic [3:0] ALU_MOD  = 4'b0101;
  localparam logic [3:0] ALU_JL   = 4'b1110;

  localparam logic [2:0] PR_AND    = 3'b001;
  localparam logic [2:0] PR_ISZERO = 3'b111;

  typedef struct packed {
    logic [EXC_W-1:0] ex_ctrl;
    logic             reg_we;
    logic             pred_we;
    logic             mem_rd;
    logic             mem_wr;
    logic             illegal;
    logic             use_ry;
    logic             use_rx;
  } dec_t;

  function automatic logic [EXC_W-1:0] mk_ctrl(
    input logic       src1_pc,
    input logic       src2_imm,
    input logic [3:0] op,
    input logic       int_sel
  );
    return {src1_pc, src2_imm, op, int_sel};
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational opcode decode into EX control word and side controls.
// Illegal encodings zero every control but keep operand-read flags.
module id_decoder
  import ex_pkg::*;
(
  input  logic [5:0] i_opcode,
  output dec_t       o_dec
);

  logic [1:0] w_cls;
  logic [3:0] w_fn;
  logic       w_int_ok;
  logic       w_pred_ok;

  assign w_cls     = i_opcode[5:4];
  assign w_fn      = i_opcode[3:0];
  assign w_int_ok  = (w_fn != 4'h0) && (w_fn != 4'hF);
  assign w_pred_ok = !w_fn[3] && (w_fn[2:0] != 3'b000);

  always_comb begin
    o_dec = '0;
    // Register reads depend only on format, so hazards see them even if illegal
    o_dec.use_ry = (w_cls != CLS_MISC) || (i_opcode == OP_LD)
                || (i_opcode == OP_ST);
    o_dec.use_rx = (w_cls == CLS_INT_RR) || (w_cls == CLS_PRED)
                || (i_opcode == OP_ST);
    unique case (1'b1)
      (w_cls == CLS_INT_RR) && w_int_ok: begin
        o_dec.ex_ctrl = mk_ctrl(1'b0, 1'b0, w_fn, 1'b1);
        o_dec.reg_we  = 1'b1;
      end
      (w_cls == CLS_INT_RI) && w_int_ok: begin
        o_dec.ex_ctrl = mk_ctrl(1'b0, 1'b1, w_fn, 1'b1);
        o_dec.reg_we  = 1'b1;
      end
      (w_cls == CLS_PRED) && w_pred_ok: begin
        o_dec.ex_ctrl = mk_ctrl(1'b0, 1'b0, {1'b0, w_fn[2:0]}, 1'b0);
        o_dec.pred_we = 1'b1;
      end
      i_opcode == OP_JAL: begin
        o_dec.ex_ctrl = mk_ctrl(1'b1, 1'b0, ALU_JL, 1'b1);
        o_dec.reg_we  = 1'b1;
      end
      i_opcode == OP_LD: begin
        o_dec.ex_ctrl = mk_ctrl(1'b0, 1'b1, ALU_ADD, 1'b1);
        o_dec.reg_we  = 1'b1;
        o_dec.mem_rd  = 1'b1;
      end
      i_opcode == OP_ST: begin
        o_dec.ex_ctrl = mk_ctrl(1'b0, 1'b1, ALU_ADD, 1'b1);
        o_dec.mem_wr  = 1'b1;
      end
      i_opcode == OP_NOP: begin
        o_dec.ex_ctrl = '0;
      end
      default: begin
        o_dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_decode_stage.sv
// Decode stage: ID/EX pipeline register, valid/ready handshake,
// flush and single-bubble load-use interlock.
module id_decode_stage
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_INC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXC_W-1:0]  ex_ctrl,
  output logic [DATA_W-1:0] imm_s,
  output logic [DATA_W-1:0] pc_n,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] ry_sel,
  output logic [REG_AW-1:0] rx_sel,
  output logic              reg_we,
  output logic              pred_we,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              illegal
);

  dec_t              w_dec;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_ry;
  logic [REG_AW-1:0] w_rx;
  logic              w_hit;
  logic              w_hazard;
  logic              w_accept;

  logic              r_valid;
  logic [EXC_W-1:0]  r_ctrl;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pcn;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_ry;
  logic [REG_AW-1:0] r_rx;
  logic              r_reg_we;
  logic              r_pred_we;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic              r_illegal;

  id_decoder u_dec (
    .i_opcode (instr[31:26]),
    .o_dec    (w_dec)
  );

  assign w_rd = instr[25 -: REG_AW];
  assign w_ry = instr[20 -: REG_AW];
  assign w_rx = instr[15 -: REG_AW];

  assign w_hit = (w_dec.use_ry && (w_ry == r_rd))
              || (w_dec.use_rx && (w_rx == r_rd));
  assign w_hazard = r_valid && r_mem_rd && (r_rd != '0)
                 && in_valid && w_hit;

  assign in_ready = (!r_valid || out_ready) && !w_hazard && !flush;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_imm     <= '0;
      r_pcn     <= '0;
      r_rd      <= '0;
      r_ry      <= '0;
      r_rx      <= '0;
      r_reg_we  <= 1'b0;
      r_pred_we <= 1'b0;
      r_mem_rd  <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_ctrl    <= w_dec.ex_ctrl;
      r_imm     <= {{(DATA_W-16){instr[15]}}, instr[15:0]};
      r_pcn     <= pc + DATA_W'(PC_INC);
      r_rd      <= w_rd;
      r_ry      <= w_ry;
      r_rx      <= w_rx;
      r_reg_we  <= w_dec.reg_we;
      r_pred_we <= w_dec.pred_we;
      r_mem_rd  <= w_dec.mem_rd;
      r_mem_wr  <= w_dec.mem_wr;
      r_illegal <= w_dec.illegal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign ex_ctrl   = r_ctrl;
  assign imm_s     = r_imm;
  assign pc_n      = r_pcn;
  assign rd        = r_rd;
  assign ry_sel    = r_ry;
  assign rx_sel    = r_rx;
  assign reg_we    = r_reg_we;
  assign pred_we   = r_pred_we;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: directed cases then random traffic
// checked against an arithmetic reference decoder.
module tb_id_decode_stage;

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [31:0] imm;
    logic [31:0] pcn;
    logic [4:0]  rd;
    logic [4:0]  ry;
    logic [4:0]  rx;
    logic        reg_we;
    logic        pred_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [6:0]  ex_ctrl;
  logic [31:0] imm_s;
  logic [31:0] pc_n;
  logic [4:0]  rd;
  logic [4:0]  ry_sel;
  logic [4:0]  rx_sel;
  logic        reg_we;
  logic        pred_we;
  logic        mem_rd;
  logic        mem_wr;
  logic        illegal;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  logic m_valid = 1'b0;
  exp_t m_ent = '0;
  logic m_rst_chk = 1'b0;

  always #5 clk = ~clk;

  id_decode_stage #(.DATA_W(32), .REG_AW(5), .PC_INC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ex_ctrl   (ex_ctrl),
    .imm_s     (imm_s),
    .pc_n      (pc_n),
    .rd        (rd),
    .ry_sel    (ry_sel),
    .rx_sel    (rx_sel),
    .reg_we    (reg_we),
    .pred_we   (pred_we),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .illegal   (illegal)
  );

  function automatic logic [31:0] mk(input logic [5:0] op,
    input logic [4:0] d, input logic [4:0] s, input logic [15:0] im);
    return {op, d, s, im};
  endfunction

  // Reference decode from the class rules, using integer arithmetic
  function automatic exp_t ref_dec(input logic [31:0] i, input logic [31:0] p);
    exp_t e;
    int   op, cls, f;
    e = '0;
    op  = int'(i[31:26]);
    cls = op / 16;
    f   = op % 16;
    e.imm = {{16{i[15]}}, i[15:0]};
    e.pcn = p + 32'd4;
    e.rd  = i[25:21];
    e.ry  = i[20:16];
    e.rx  = i[15:11];
    if (cls <= 1) begin
      if (f >= 1 && f <= 14) begin
        e.ctrl = 7'(cls * 32 + f * 2 + 1);
        e.reg_we = 1'b1;
      end else e.ill = 1'b1;
    end else if (cls == 2) begin
      if (f >= 1 && f <= 7) begin
        e.ctrl = 7'(f * 2);
        e.pred_we = 1'b1;
      end else e.ill = 1'b1;
    end else begin
      case (op)
        'h30: begin e.ctrl = 7'(64 + 14 * 2 + 1); e.reg_we = 1'b1; end
        'h31: begin e.ctrl = 7'(32 + 2 + 1); e.reg_we = 1'b1; e.mem_rd = 1'b1; end
        'h32: begin e.ctrl = 7'(32 + 2 + 1); e.mem_wr = 1'b1; end
        'h3F: e.ctrl = '0;
        default: e.ill = 1'b1;
      endcase
    end
    return e;
  endfunction

  function automatic logic reads(input logic [31:0] i, input logic [4:0] r);
    logic [5:0] op;
    op = i[31:26];
    if (op[5:4] == 2'd0 || op[5:4] == 2'd2 || op == 6'h32)
      return (i[20:16] == r) || (i[15:11] == r);
    if (op[5:4] == 2'd1 || op == 6'h31)
      return i[20:16] == r;
    return 1'b0;
  endfunction

  function automatic logic exp_rdy();
    logic haz;
    haz = m_valid && m_ent.mem_rd && (m_ent.rd != 5'd0) && in_valid
       && reads(instr, m_ent.rd);
    return (!m_valid || out_ready) && !haz && !flush;
  endfunction

  task automatic chk(input string n, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_valid = 1'b0;
      q.delete();
      m_rst_chk = 1'b1;
    end else if (flush) begin
      m_valid = 1'b0;
      q.delete();
    end else if (in_valid && exp_rdy()) begin
      m_ent = ref_dec(instr, pc);
      m_valid = 1'b1;
      q.push_back(m_ent);
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cyc(input logic iv, input logic [31:0] ins,
    input logic [31:0] p, input logic ordy, input logic fl);
    in_valid = iv;
    instr = ins;
    pc = p;
    out_ready = ordy;
    flush = fl;
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Monitor: pops expected entries as EX consumes them
  always @(negedge clk) begin
    exp_t got;
    if (rst_n) begin
      got = {ex_ctrl, imm_s, pc_n, rd, ry_sel, rx_sel,
             reg_we, pred_we, mem_rd, mem_wr, illegal};
      chk("in_ready", 64'(in_ready), 64'(exp_rdy()));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (m_rst_chk) begin
        tests++;
        if (out_valid !== 1'b0 || got !== '0) begin
          fails++;
          $display("FAIL reset_zero got=%h valid=%b exp=0", got, out_valid);
        end
        m_rst_chk = 1'b0;
      end
      if (out_valid && q.size() != 0) begin
        tests++;
        if (got !== q[0]) begin
          fails++;
          $display("FAIL sb_fields got=%h exp=%h", got, q[0]);
        end
        if (out_ready) q.delete(0);
      end
    end
  end

  initial begin
    logic [31:0] a_i, b_i, ld5, add5, ld0, add0, ri;
    logic [5:0]  rop;
    a_i  = mk(6'h02, 5'd3, 5'd1, 16'h1000);
    b_i  = mk(6'h05, 5'd4, 5'd2, 16'h0800);
    ld5  = mk(6'h31, 5'd5, 5'd1, 16'h0004);
    add5 = mk(6'h01, 5'd7, 5'd5, 16'h0800);
    ld0  = mk(6'h31, 5'd0, 5'd1, 16'h0004);
    add0 = mk(6'h01, 5'd7, 5'd0, 16'h0800);

    rst_n = 1'b0;
    cyc(0, '0, '0, 1, 0);
    cyc(0, '0, '0, 1, 0);
    rst_n = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'd0);

    cyc(1, 32'h0443_0800, 32'h100, 1, 0);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_ctrl", 64'(ex_ctrl), 64'(7'b0000011));
    chk("add_we", 64'(reg_we), 64'd1);
    chk("add_pcn", 64'(pc_n), 64'h104);
    chk("add_rd", 64'(rd), 64'd2);

    cyc(1, mk(6'h11, 5'd1, 5'd2, 16'hFFFE), 32'h200, 1, 0);
    chk("addi_imm", 64'(imm_s), 64'hFFFF_FFFE);
    chk("addi_ctrl", 64'(ex_ctrl), 64'(7'b0100011));
    cyc(1, mk(6'h30, 5'd31, 5'd0, 16'h0010), 32'h204, 1, 0);
    chk("jal_ctrl", 64'(ex_ctrl), 64'(7'b1011101));
    cyc(1, mk(6'h27, 5'd1, 5'd2, 16'h1800), 32'h208, 1, 0);
    chk("pred_ctrl", 64'(ex_ctrl), 64'(7'b0001110));
    chk("pred_we", 64'(pred_we), 64'd1);

    cyc(1, a_i, 32'h300, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, b_i, 32'h304, 0, 0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_ctrl", 64'(ex_ctrl), 64'(7'b0000101));
      chk("bp_hold_pcn", 64'(pc_n), 64'h304);
    end
    cyc(1, b_i, 32'h304, 1, 0);
    chk("bp_next_ctrl", 64'(ex_ctrl), 64'(7'b0001011));
    chk("bp_next_pcn", 64'(pc_n), 64'h308);
    cyc(0, '0, '0, 1, 0);

    cyc(1, ld5, 32'h400, 1, 0);
    cyc(1, add5, 32'h404, 1, 0);
    chk("lu_bubble", 64'(out_valid), 64'd0);
    cyc(1, add5, 32'h404, 1, 0);
    chk("lu_issue_valid", 64'(out_valid), 64'd1);
    chk("lu_issue_rd", 64'(rd), 64'd7);
    cyc(1, ld0, 32'h500, 1, 0);
    cyc(1, add0, 32'h504, 1, 0);
    chk("lu_rd0_valid", 64'(out_valid), 64'd1);
    chk("lu_rd0_ctrl", 64'(ex_ctrl), 64'(7'b0000011));

    cyc(1, ld5, 32'h600, 1, 0);
    cyc(1, add5, 32'h604, 1, 1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    cyc(0, '0, '0, 1, 0);
    chk("flush_drop", 64'(out_valid), 64'd0);

    cyc(1, mk(6'h3A, 5'd4, 5'd1, 16'h0800), 32'h700, 1, 0);
    chk("ill_flag", 64'(illegal), 64'd1);
    chk("ill_ctrl", 64'(ex_ctrl), 64'd0);
    chk("ill_we", 64'(reg_we), 64'd0);

    rst_n = 1'b0;
    cyc(1, a_i, 32'h800, 1, 0);
    rst_n = 1'b1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_pcn", 64'(pc_n), 64'd0);
    cyc(1, mk(6'h3F, 5'd0, 5'd0, 16'h0), 32'hFFFF_FFFC, 1, 0);
    chk("wrap_pcn", 64'(pc_n), 64'd0);
    chk("wrap_valid", 64'(out_valid), 64'd1);

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: rop = 6'h31;
        3:       rop = 6'h32;
        4:       rop = 6'h30;
        5:       rop = 6'h3F;
        default: rop = 6'($urandom);
      endcase
      ri = mk(rop, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              16'($urandom));
      ri[15:11] = 5'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 9) < 7, ri, $urandom,
          $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) cyc(0, '0, '0, 1, 0);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
